// File: rtl/rx_pkt_parser_pkg.sv
// Shared header-layout constants and state type for the RX packet header parser.
package rx_pkt_parser_pkg;

  localparam int unsigned HdrBytes = 11;

  // Byte offsets of the MSB of each header field.
  localparam int unsigned OffType   = 0;
  localparam int unsigned OffSrc    = 1;
  localparam int unsigned OffDst    = 3;
  localparam int unsigned OffEnergy = 5;
  localparam int unsigned OffQValue = 7;
  localparam int unsigned OffHops   = 9;
  localparam int unsigned OffCksum  = HdrBytes - 1;

  localparam logic [2:0] PktData     = 3'd4;
  localparam logic [2:0] PktTypeNone = 3'b111;

  typedef enum logic [1:0] {StIdle, StHdr, StDone} state_e;

  function automatic logic [15:0] be16(input logic [7:0] hi, input logic [7:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/pkt_timeout_timer.sv
// Idle-cycle counter for the header parser; flags expiry after TIMEOUT_CYC idle cycles.
module pkt_timeout_timer #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic nrst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

  logic [CntW-1:0] count_q, count_d;

  assign expired = enable && (count_q == CntW'(TIMEOUT_CYC));

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/rx_pkt_parser.sv
// RX header parser: assembles the 11-byte header, checks XOR checksum and type, and
// publishes the fields with a one-cycle newpkt (or pkt_err) pulse.
module rx_pkt_parser
  import rx_pkt_parser_pkg::*;
#(
  parameter int unsigned WORD_WIDTH   = 16,
  parameter int unsigned TIMEOUT_CYC  = 64,
  parameter logic [2:0]  MAX_PKT_TYPE = PktData
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [7:0]            rx_byte,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [2:0]            fPktType,
  output logic [WORD_WIDTH-1:0] fSourceID,
  output logic [WORD_WIDTH-1:0] fDestinationID,
  output logic [WORD_WIDTH-1:0] fEnergy,
  output logic [WORD_WIDTH-1:0] fQValue,
  output logic [7:0]            fHops,
  output logic                  newpkt,
  output logic                  pkt_err,
  output logic                  busy
);

  state_e state_q, state_d;

  logic [3:0] cnt_q, cnt_d;
  logic [7:0] xor_q, xor_d;
  // Shadow copy of bytes 0..9; byte 10 is only compared, never stored.
  logic [7:0] hdr_q [OffCksum];
  logic [7:0] hdr_d [OffCksum];

  logic [2:0]            f_type_q, f_type_d;
  logic [WORD_WIDTH-1:0] f_src_q, f_src_d;
  logic [WORD_WIDTH-1:0] f_dst_q, f_dst_d;
  logic [WORD_WIDTH-1:0] f_energy_q, f_energy_d;
  logic [WORD_WIDTH-1:0] f_qvalue_q, f_qvalue_d;
  logic [7:0]            f_hops_q, f_hops_d;
  logic                  newpkt_q, newpkt_d;
  logic                  pkt_err_q, pkt_err_d;

  logic accept, timeout, last_byte, hdr_ok, tmr_clear, tmr_enable;

  assign accept    = rx_valid && rx_ready;
  assign last_byte = (state_q == StHdr) && accept && !timeout && (cnt_q == 4'(OffCksum));
  assign hdr_ok    = (rx_byte == xor_q) && (hdr_q[OffType] <= {5'b0, MAX_PKT_TYPE});

  assign tmr_enable = (state_q == StHdr);
  assign tmr_clear  = (state_q != StHdr) || accept || timeout;

  pkt_timeout_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .nrst   (nrst),
    .clear  (tmr_clear),
    .enable (tmr_enable),
    .expired(timeout)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StHdr;
      StHdr: begin
        if (timeout) begin
          state_d = StIdle;
        end else if (last_byte) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rx_ready = (state_q != StDone);
    busy     = (state_q != StIdle);
  end

  always_comb begin
    cnt_d      = cnt_q;
    xor_d      = xor_q;
    hdr_d      = hdr_q;
    f_type_d   = f_type_q;
    f_src_d    = f_src_q;
    f_dst_d    = f_dst_q;
    f_energy_d = f_energy_q;
    f_qvalue_d = f_qvalue_q;
    f_hops_d   = f_hops_q;
    newpkt_d   = 1'b0;
    pkt_err_d  = 1'b0;
    if (timeout) begin
      // A byte presented in the expiry cycle is dropped along with the packet.
      cnt_d     = '0;
      xor_d     = '0;
      pkt_err_d = 1'b1;
    end else if (last_byte) begin
      cnt_d = '0;
      xor_d = '0;
      if (hdr_ok) begin
        newpkt_d   = 1'b1;
        f_type_d   = hdr_q[OffType][2:0];
        f_src_d    = WORD_WIDTH'(be16(hdr_q[OffSrc], hdr_q[OffSrc+1]));
        f_dst_d    = WORD_WIDTH'(be16(hdr_q[OffDst], hdr_q[OffDst+1]));
        f_energy_d = WORD_WIDTH'(be16(hdr_q[OffEnergy], hdr_q[OffEnergy+1]));
        f_qvalue_d = WORD_WIDTH'(be16(hdr_q[OffQValue], hdr_q[OffQValue+1]));
        f_hops_d   = hdr_q[OffHops];
      end else begin
        pkt_err_d = 1'b1;
      end
    end else if (accept) begin
      hdr_d[cnt_q] = rx_byte;
      cnt_d        = cnt_q + 1'b1;
      xor_d        = xor_q ^ rx_byte;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q      <= '0;
      xor_q      <= '0;
      hdr_q      <= '{default: '0};
      f_type_q   <= PktTypeNone;
      f_src_q    <= '0;
      f_dst_q    <= '0;
      f_energy_q <= '0;
      f_qvalue_q <= '0;
      f_hops_q   <= '0;
      newpkt_q   <= 1'b0;
      pkt_err_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      xor_q      <= xor_d;
      hdr_q      <= hdr_d;
      f_type_q   <= f_type_d;
      f_src_q    <= f_src_d;
      f_dst_q    <= f_dst_d;
      f_energy_q <= f_energy_d;
      f_qvalue_q <= f_qvalue_d;
      f_hops_q   <= f_hops_d;
      newpkt_q   <= newpkt_d;
      pkt_err_q  <= pkt_err_d;
    end
  end

  assign fPktType       = f_type_q;
  assign fSourceID      = f_src_q;
  assign fDestinationID = f_dst_q;
  assign fEnergy        = f_energy_q;
  assign fQValue        = f_qvalue_q;
  assign fHops          = f_hops_q;
  assign newpkt         = newpkt_q;
  assign pkt_err        = pkt_err_q;

endmodule
